// File: rtl/axi_grid_link_arb.sv
// Packet-aware round-robin arbiter that shares one grid link among NUM_REQ sources.
// A grant is held from the first accepted beat of a multi-beat packet until its
// last beat is accepted, so bursts from different sources never interleave.
// The link side is driven from a single registered stage that can accept and
// drain in the same cycle, sustaining one beat per cycle.
module axi_grid_link_arb #(
   parameter int  NUM_REQ = 4,
   parameter int  DATA_W  = 64,
   localparam int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk_i,
   input  logic                      arst_i,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]        req_last_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   output logic                      out_valid_o,
   output logic [DATA_W-1:0]         out_data_o,
   output logic                      out_last_o,
   output logic [SRC_W-1:0]          out_src_o,
   input  logic                      out_ready_i,
   output logic                      busy_o
);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t             state, state_next;
   logic [SRC_W-1:0]   rr_ptr, rr_next;
   logic [SRC_W-1:0]   gnt, gnt_next;
   logic [SRC_W-1:0]   sel;
   logic               sel_found;
   logic [SRC_W-1:0]   cur;
   logic               cur_valid;
   logic               cur_last;
   logic [DATA_W-1:0]  cur_data;
   logic [NUM_REQ-1:0] cur_onehot;
   logic               can_load;
   logic               accept;
   logic [2*NUM_REQ-1:0] valid_dbl;
   logic [NUM_REQ-1:0]   valid_rot;

   // Output register stage (p1): valid, payload, last flag and source index
   logic               vld_p1;
   logic [DATA_W-1:0]  data_p1;
   logic               last_p1;
   logic [SRC_W-1:0]   src_p1;

   // Round-robin successor of a source index, wrapping at NUM_REQ
   function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] idx);
      if (int'(idx) >= NUM_REQ - 1) return '0;
      else                         return idx + 1'b1;
   endfunction

   assign can_load = ~vld_p1 | out_ready_i;

   // Rotate the request vector so bit 0 is the rr_ptr source, then take the first set bit
   assign valid_dbl = {req_valid_i, req_valid_i};
   assign valid_rot = valid_dbl[NUM_REQ-1:0] == '0 ? '0 : NUM_REQ'(valid_dbl >> rr_ptr);

   // Combinational round-robin pick among currently valid sources
   always_comb begin
      logic [SRC_W:0] sum;
      sel       = '0;
      sel_found = 1'b0;
      sum       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!sel_found && valid_rot[i]) begin
            sum = {1'b0, rr_ptr} + (SRC_W+1)'(i);
            if (sum >= (SRC_W+1)'(NUM_REQ)) sum = sum - (SRC_W+1)'(NUM_REQ);
            sel       = sum[SRC_W-1:0];
            sel_found = 1'b1;
         end
      end
   end

   // Mux the serviced source (held grant while LOCKED, fresh pick while IDLE)
   always_comb begin
      cur        = (state == LOCKED) ? gnt : sel;
      cur_valid  = 1'b0;
      cur_last   = 1'b0;
      cur_data   = '0;
      cur_onehot = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (cur == SRC_W'(k)) begin
            cur_valid     = req_valid_i[k];
            cur_last      = req_last_i[k];
            cur_data      = req_data_i[k*DATA_W +: DATA_W];
            cur_onehot[k] = 1'b1;
         end
      end
   end

   // FSM next state, round-robin pointer, grant and per-source ready
   always_comb begin
      state_next  = state;
      rr_next     = rr_ptr;
      gnt_next    = gnt;
      req_ready_o = '0;
      accept      = 1'b0;
      case (state)
         IDLE: begin
            if (sel_found && can_load) req_ready_o = cur_onehot;
            accept = sel_found & can_load;
            if (accept) begin
               rr_next = wrap_inc(sel);
               if (!cur_last) begin
                  gnt_next   = sel;
                  state_next = LOCKED;
               end
            end
         end
         LOCKED: begin
            if (can_load) req_ready_o = cur_onehot;
            accept = cur_valid & can_load;
            if (accept && cur_last) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // FSM state, round-robin pointer and held grant
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state  <= IDLE;
         rr_ptr <= '0;
         gnt    <= '0;
      end else begin
         state  <= state_next;
         rr_ptr <= rr_next;
         gnt    <= gnt_next;
      end
   end

   // Link output register: load on accept, clear valid on drain, hold under backpressure
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         last_p1 <= 1'b0;
         src_p1  <= '0;
      end else if (can_load) begin
         vld_p1 <= accept;
         if (accept) begin
            data_p1 <= cur_data;
            last_p1 <= cur_last;
            src_p1  <= cur;
         end
      end
   end

   assign out_valid_o = vld_p1;
   assign out_data_o  = data_p1;
   assign out_last_o  = last_p1;
   assign out_src_o   = src_p1;
   assign busy_o      = (state == LOCKED) | vld_p1;

endmodule

// File: tb/tb_axi_grid_link_arb.sv
// Directed and randomised bench for the packet-aware round-robin link arbiter.
module tb_axi_grid_link_arb;
   localparam int N  = 4;
   localparam int DW = 64;

   logic            clk = 1'b0;
   logic            arst;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_last;
   logic [N-1:0]    req_ready;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic            out_last;
   logic [1:0]      out_src;
   logic            out_ready;
   logic            busy;

   int checks = 0;
   int errors = 0;

   axi_grid_link_arb #(.NUM_REQ(N), .DATA_W(DW)) dut (
      .clk_i       (clk),
      .arst_i      (arst),
      .req_valid_i (req_valid),
      .req_data_i  (req_data),
      .req_last_i  (req_last),
      .req_ready_o (req_ready),
      .out_valid_o (out_valid),
      .out_data_o  (out_data),
      .out_last_o  (out_last),
      .out_src_o   (out_src),
      .out_ready_i (out_ready),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      out_ready = 1'b1;
   endtask

   task automatic set_src(input int k, input logic v, input logic [DW-1:0] d, input logic l);
      req_valid[k]            = v;
      req_data[k*DW +: DW]    = d;
      req_last[k]             = l;
   endtask

   function automatic logic [DW-1:0] pat(input int k);
      logic [DW-1:0] r;
      r = {8{8'(k + 1)}};
      return r;
   endfunction

   function automatic logic [DW-1:0] mk(input int k, input int s, input int b, input logic l);
      logic [DW-1:0] r;
      r = {24'h0, 8'(k), 16'(s), 8'(b), 7'h0, l};
      return r;
   endfunction

   task automatic do_reset();
      clear_inputs();
      arst = 1'b1;
      tick();
      tick();
      arst = 1'b0;
   endtask

   task automatic test_reset();
      arst = 1'b1;
      clear_inputs();
      tick();
      checks++;
      if ({out_valid, out_last, out_src, busy, req_ready} !== 9'b0 || out_data !== '0) begin
         errors++;
         $display("FAIL rst_init valid=%b last=%b src=%0d busy=%b ready=%b data=%h required all 0",
                  out_valid, out_last, out_src, busy, req_ready, out_data);
      end
      arst = 1'b0;
      set_src(2, 1'b1, pat(2), 1'b0);
      tick();
      checks++;
      if (busy !== 1'b1 || out_src !== 2'd2) begin
         errors++;
         $display("FAIL rst_prepkt busy=%b src=%0d required busy=1 src=2", busy, out_src);
      end
      #2;
      clear_inputs();
      arst = 1'b1;
      #1;
      checks++;
      if ({out_valid, out_last, out_src, busy, req_ready} !== 9'b0 || out_data !== '0) begin
         errors++;
         $display("FAIL rst_midpkt valid=%b last=%b src=%0d busy=%b ready=%b data=%h required all 0",
                  out_valid, out_last, out_src, busy, req_ready, out_data);
      end
      tick();
      arst = 1'b0;
      set_src(0, 1'b1, pat(0), 1'b1);
      set_src(2, 1'b1, pat(2), 1'b1);
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL rst_first_ready ready=%b required 0001", req_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== pat(0)) begin
         errors++;
         $display("FAIL rst_first_grant valid=%b src=%0d required valid=1 src=0", out_valid, out_src);
      end
   endtask

   task automatic test_rr_single();
      logic [1:0] e;
      do_reset();
      for (int k = 0; k < N; k++) set_src(k, 1'b1, pat(k), 1'b1);
      for (int i = 0; i < 8; i++) begin
         tick();
         e = 2'(i % N);
         checks++;
         if (out_valid !== 1'b1 || out_src !== e || out_data !== pat(int'(e)) || out_last !== 1'b1) begin
            errors++;
            $display("FAIL rr_beat%0d valid=%b src=%0d last=%b required valid=1 src=%0d last=1",
                     i, out_valid, out_src, out_last, e);
         end
      end
   endtask

   task automatic test_burst_lock();
      do_reset();
      set_src(0, 1'b1, pat(0), 1'b1);
      tick();
      set_src(2, 1'b1, pat(2), 1'b1);
      for (int b = 0; b < 4; b++) begin
         set_src(1, 1'b1, 64'h1000 + 64'(b), (b == 3));
         #1;
         checks++;
         if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL lock_ready%0d ready=%b required 0010", b, req_ready);
         end
         tick();
         checks++;
         if (out_src !== 2'd1 || out_data !== 64'h1000 + 64'(b) || out_last !== (b == 3)) begin
            errors++;
            $display("FAIL lock_beat%0d src=%0d data=%h last=%b required src=1 data=%h last=%b",
                     b, out_src, out_data, out_last, 64'h1000 + 64'(b), (b == 3));
         end
      end
      set_src(1, 1'b0, '0, 1'b0);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_src !== 2'd2 || out_last !== 1'b1) begin
         errors++;
         $display("FAIL lock_after1 valid=%b src=%0d required valid=1 src=2", out_valid, out_src);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_src !== 2'd0) begin
         errors++;
         $display("FAIL lock_after2 valid=%b src=%0d required valid=1 src=0", out_valid, out_src);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int k = 0; k < N; k++) set_src(k, 1'b1, pat(k), 1'b1);
      tick();
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL bp_ready%0d ready=%b required 0000", c, req_ready);
         end
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== pat(0)) begin
            errors++;
            $display("FAIL bp_hold%0d valid=%b src=%0d data=%h required valid=1 src=0 data=%h",
                     c, out_valid, out_src, out_data, pat(0));
         end
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== pat(1)) begin
         errors++;
         $display("FAIL bp_release1 valid=%b src=%0d required valid=1 src=1", out_valid, out_src);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_src !== 2'd2) begin
         errors++;
         $display("FAIL bp_release2 valid=%b src=%0d required valid=1 src=2", out_valid, out_src);
      end
   endtask

   task automatic test_lock_gap();
      do_reset();
      set_src(3, 1'b1, 64'h3000, 1'b0);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_src !== 2'd3) begin
         errors++;
         $display("FAIL gap_first valid=%b src=%0d required valid=1 src=3", out_valid, out_src);
      end
      set_src(3, 1'b0, 64'h3000, 1'b0);
      set_src(0, 1'b1, pat(0), 1'b1);
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if (req_ready[0] !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL gap_hold%0d ready=%b busy=%b required ready[0]=0 busy=1", c, req_ready, busy);
         end
         tick();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL gap_idle%0d valid=%b src=%0d required valid=0", c, out_valid, out_src);
         end
      end
      set_src(3, 1'b1, 64'h3001, 1'b1);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_src !== 2'd3 || out_data !== 64'h3001 || out_last !== 1'b1) begin
         errors++;
         $display("FAIL gap_second valid=%b src=%0d data=%h last=%b required src=3 data=3001 last=1",
                  out_valid, out_src, out_data, out_last);
      end
      set_src(3, 1'b0, '0, 1'b0);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_src !== 2'd0) begin
         errors++;
         $display("FAIL gap_then_src0 valid=%b src=%0d required valid=1 src=0", out_valid, out_src);
      end
   endtask

   task automatic test_random();
      int beat[N];
      int len[N];
      int seq[N];
      int exp_seq[N];
      int exp_beat[N];
      int wait_cnt[N];
      int beats_out;
      int s;
      bit inflight;
      logic [1:0] prev_src;
      logic [N-1:0] rdy;
      logic [DW-1:0] d;
      logic l;
      do_reset();
      for (int k = 0; k < N; k++) begin
         beat[k] = 0; len[k] = 1; seq[k] = 0;
         exp_seq[k] = 0; exp_beat[k] = 0; wait_cnt[k] = 0;
      end
      beats_out = 0;
      inflight  = 1'b0;
      prev_src  = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int k = 0; k < N; k++) begin
            if (!req_valid[k] && $urandom_range(0, 2) == 0) begin
               if (beat[k] == 0) begin
                  len[k]      = $urandom_range(1, 4);
                  wait_cnt[k] = 0;
               end
               l = (beat[k] == len[k] - 1);
               set_src(k, 1'b1, mk(k, seq[k], beat[k], l), l);
            end
         end
         out_ready = ($urandom_range(0, 9) < 7);
         #1;
         rdy = req_ready;
         if (out_valid && out_ready) begin
            d = out_data;
            s = int'(out_src);
            beats_out++;
            checks++;
            if (d[39:32] !== {6'b0, out_src}) begin
               errors++;
               $display("FAIL rnd_src cyc=%0d src=%0d payload_src=%0d", cyc, out_src, d[39:32]);
            end
            if (inflight) begin
               checks++;
               if (out_src !== prev_src) begin
                  errors++;
                  $display("FAIL rnd_interleave cyc=%0d src=%0d required %0d", cyc, out_src, prev_src);
               end
            end
            checks++;
            if (d[31:16] !== 16'(exp_seq[s]) || d[15:8] !== 8'(exp_beat[s])) begin
               errors++;
               $display("FAIL rnd_order cyc=%0d src=%0d seq=%0d beat=%0d required seq=%0d beat=%0d",
                        cyc, s, d[31:16], d[15:8], exp_seq[s], exp_beat[s]);
            end
            checks++;
            if (out_last !== d[0]) begin
               errors++;
               $display("FAIL rnd_last cyc=%0d last=%b required %b", cyc, out_last, d[0]);
            end
            if (out_last) begin
               exp_seq[s]++;
               exp_beat[s] = 0;
               inflight    = 1'b0;
            end else begin
               exp_beat[s]++;
               inflight = 1'b1;
               prev_src = out_src;
            end
         end
         tick();
         for (int k = 0; k < N; k++) begin
            if (req_valid[k] && rdy[k]) begin
               if (beat[k] == 0) begin
                  checks++;
                  if (wait_cnt[k] > N - 1) begin
                     errors++;
                     $display("FAIL rnd_wait cyc=%0d src=%0d waited %0d packets, limit %0d",
                              cyc, k, wait_cnt[k], N - 1);
                  end
                  for (int j = 0; j < N; j++)
                     if (j != k && req_valid[j] && beat[j] == 0) wait_cnt[j]++;
               end
               req_valid[k] = 1'b0;
               if (req_last[k]) begin
                  beat[k] = 0;
                  seq[k]++;
               end else begin
                  beat[k]++;
               end
            end
         end
      end
      checks++;
      if (beats_out < 500) begin
         errors++;
         $display("FAIL rnd_throughput beats=%0d required at least 500", beats_out);
      end
   endtask

   initial begin
      test_reset();
      test_rr_single();
      test_burst_lock();
      test_backpressure();
      test_lock_gap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
